io_pad_arbiter: RTL and testbench

Arbiter that shares the user IO pad bank (east 14, west 14, north 10 pads) among the macros of the grid. Each macro requests ownership; one macro at a time is granted, round-robin with a bounded time slice. Its `_o`/`_oe` buses are muxed onto the pads. A forced break-before-make turnaround (all `oe` low) separates successive owners. The block sits between the macro array and the pad ring at grid top level.

---
 rtl/io_pad_pkg.sv | 23 ++
 rtl/io_pad_arbiter_rr_pick.sv | 31 +++
 rtl/io_pad_arbiter.sv | 179 +++++++++++++++++
 tb/tb_io_pad_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pad_pkg.sv
// Shared definitions for the user IO pad arbiter: default pad widths,
// default timing, the arbiter state encoding and a counter width helper.
package io_pad_pkg;

    localparam int DEF_N_MACROS     = 4;
    localparam int DEF_EAST_W       = 14;
    localparam int DEF_WEST_W       = 14;
    localparam int DEF_NORTH_W      = 10;
    localparam int DEF_SLICE_CYCLES = 256;
    localparam int DEF_TURN_CYCLES  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_pad_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first requester
// at or after ptr (cyclically) as a one-hot vector and as an index.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan candidates ptr, ptr+1, ... wrapping at N and keep the first hit.
    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/io_pad_arbiter.sv
// io_pad_arbiter: shares the east/west/north user pad bank among the grid
// macros. Round-robin ownership with a bounded time slice and a forced
// all-undriven turnaround between owners.
// Optional feature: define IO_ARB_LOCK_EN to add lock_i, which lets the
// current owner suppress preemption while its lock bit is high.
module io_pad_arbiter
    import io_pad_pkg::*;
#(
    parameter int N_MACROS     = DEF_N_MACROS,
    parameter int EAST_W       = DEF_EAST_W,
    parameter int WEST_W       = DEF_WEST_W,
    parameter int NORTH_W      = DEF_NORTH_W,
    parameter int SLICE_CYCLES = DEF_SLICE_CYCLES,
    parameter int TURN_CYCLES  = DEF_TURN_CYCLES,
    localparam int IDX_W       = $clog2(N_MACROS)
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [N_MACROS-1:0]         req_i,
`ifdef IO_ARB_LOCK_EN
    input  logic [N_MACROS-1:0]         lock_i,
`endif
    input  logic [N_MACROS*EAST_W-1:0]  east_o_i,
    input  logic [N_MACROS*EAST_W-1:0]  east_oe_i,
    input  logic [N_MACROS*WEST_W-1:0]  west_o_i,
    input  logic [N_MACROS*WEST_W-1:0]  west_oe_i,
    input  logic [N_MACROS*NORTH_W-1:0] north_o_i,
    input  logic [N_MACROS*NORTH_W-1:0] north_oe_i,
    output logic [N_MACROS-1:0]         grant_o,
    output logic [IDX_W-1:0]            owner_o,
    output logic                        busy_o,
    output logic [EAST_W-1:0]           io_east_o,
    output logic [EAST_W-1:0]           io_east_oe,
    output logic [WEST_W-1:0]           io_west_o,
    output logic [WEST_W-1:0]           io_west_oe,
    output logic [NORTH_W-1:0]          io_north_o,
    output logic [NORTH_W-1:0]          io_north_oe
);

    localparam int SLICE_W = ctr_width(SLICE_CYCLES);
    localparam int TURN_W  = ctr_width(TURN_CYCLES);

    arb_state_t          state, state_next;
    logic [N_MACROS-1:0] grant_next;
    logic [IDX_W-1:0]    owner_next;
    logic [IDX_W-1:0]    ptr, ptr_next;
    logic [SLICE_W-1:0]  slice_cnt, slice_next;
    logic [TURN_W-1:0]   turn_cnt, turn_next;

    logic [N_MACROS-1:0] pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    logic                owner_release;
    logic                other_req;
    logic                owner_lock;
    logic                slice_at_max;
    logic [IDX_W-1:0]    ptr_after_owner;

    rr_pick #(
        .N     (N_MACROS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_release   = ~|(req_i & grant_o);
    assign other_req       = |(req_i & ~grant_o);
    assign slice_at_max    = (slice_cnt == SLICE_W'(SLICE_CYCLES - 1));
    assign ptr_after_owner = (owner_o == IDX_W'(N_MACROS - 1)) ? '0 : owner_o + IDX_W'(1);
    assign busy_o          = (state == GRANT);

`ifdef IO_ARB_LOCK_EN
    assign owner_lock = |(lock_i & grant_o);
`else
    assign owner_lock = 1'b0;
`endif

    // State, grant, owner, pointer and counters; reset clears grant so pads release at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            grant_o   <= '0;
            owner_o   <= '0;
            ptr       <= '0;
            slice_cnt <= '0;
            turn_cnt  <= '0;
        end else begin
            state     <= state_next;
            grant_o   <= grant_next;
            owner_o   <= owner_next;
            ptr       <= ptr_next;
            slice_cnt <= slice_next;
            turn_cnt  <= turn_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, release/preempt in GRANT, count out TURN.
    always_comb begin
        state_next = state;
        grant_next = grant_o;
        owner_next = owner_o;
        ptr_next   = ptr;
        slice_next = slice_cnt;
        turn_next  = turn_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = GRANT;
                    grant_next = pick_gnt;
                    owner_next = pick_idx;
                    slice_next = '0;
                end
            end
            GRANT: begin
                if (owner_release || (slice_at_max && other_req && !owner_lock)) begin
                    state_next = TURN;
                    grant_next = '0;
                    ptr_next   = ptr_after_owner;
                    turn_next  = '0;
                end else if (!slice_at_max) begin
                    slice_next = slice_cnt + SLICE_W'(1);
                end
            end
            TURN: begin
                if (turn_cnt == TURN_W'(TURN_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    turn_next = turn_cnt + TURN_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // East pad mux: AND-OR select on the registered one-hot grant.
    always_comb begin
        io_east_o  = '0;
        io_east_oe = '0;
        for (int k = 0; k < N_MACROS; k++) begin
            if (grant_o[k]) begin
                io_east_o  = io_east_o  | east_o_i[k*EAST_W +: EAST_W];
                io_east_oe = io_east_oe | east_oe_i[k*EAST_W +: EAST_W];
            end
        end
    end

    // West pad mux: AND-OR select on the registered one-hot grant.
    always_comb begin
        io_west_o  = '0;
        io_west_oe = '0;
        for (int k = 0; k < N_MACROS; k++) begin
            if (grant_o[k]) begin
                io_west_o  = io_west_o  | west_o_i[k*WEST_W +: WEST_W];
                io_west_oe = io_west_oe | west_oe_i[k*WEST_W +: WEST_W];
            end
        end
    end

    // North pad mux: AND-OR select on the registered one-hot grant.
    always_comb begin
        io_north_o  = '0;
        io_north_oe = '0;
        for (int k = 0; k < N_MACROS; k++) begin
            if (grant_o[k]) begin
                io_north_o  = io_north_o  | north_o_i[k*NORTH_W +: NORTH_W];
                io_north_oe = io_north_oe | north_oe_i[k*NORTH_W +: NORTH_W];
            end
        end
    end

endmodule

// File: tb/tb_io_pad_arbiter.sv
// Directed testbench for io_pad_arbiter with SLICE_CYCLES=8, TURN_CYCLES=1.
// Lock scenario is built only when IO_ARB_LOCK_EN is defined.
module tb_io_pad_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
`ifdef IO_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [55:0] east_o, east_oe, west_o, west_oe;
    logic [39:0] north_o, north_oe;

    logic [3:0]  grant_o;
    logic [1:0]  owner_o;
    logic        busy_o;
    logic [13:0] io_east_o, io_east_oe, io_west_o, io_west_oe;
    logic [9:0]  io_north_o, io_north_oe;

    int checks = 0;
    int errors = 0;

    io_pad_arbiter #(
        .N_MACROS     (4),
        .EAST_W       (14),
        .WEST_W       (14),
        .NORTH_W      (10),
        .SLICE_CYCLES (8),
        .TURN_CYCLES  (1)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_i       (req),
`ifdef IO_ARB_LOCK_EN
        .lock_i      (lock),
`endif
        .east_o_i    (east_o),
        .east_oe_i   (east_oe),
        .west_o_i    (west_o),
        .west_oe_i   (west_oe),
        .north_o_i   (north_o),
        .north_oe_i  (north_oe),
        .grant_o     (grant_o),
        .owner_o     (owner_o),
        .busy_o      (busy_o),
        .io_east_o   (io_east_o),
        .io_east_oe  (io_east_oe),
        .io_west_o   (io_west_o),
        .io_west_oe  (io_west_oe),
        .io_north_o  (io_north_o),
        .io_north_oe (io_north_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected %b", grant_o, 4'b0000); end
        checks++; if (io_east_oe !== 14'h0000) begin errors++; $display("[TB] FAIL reset_east_oe: got %h expected %h", io_east_oe, 14'h0000); end
        checks++; if (io_east_o !== 14'h0000) begin errors++; $display("[TB] FAIL reset_east_o: got %h expected %h", io_east_o, 14'h0000); end
        checks++; if (owner_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_owner: got %0d expected %0d", owner_o, 0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected %b", busy_o, 1'b0); end
        rst = 1'b0;
        tick();
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("[TB] FAIL first_grant: got %b expected %b", grant_o, 4'b0001); end
        checks++; if (io_east_o !== 14'h0001) begin errors++; $display("[TB] FAIL first_east_o: got %h expected %h", io_east_o, 14'h0001); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL first_busy: got %b expected %b", busy_o, 1'b1); end
    endtask

    task automatic test_single_owner();
        do_reset();
        req = 4'b0100;
        tick();
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant: got %b expected %b", grant_o, 4'b0100); end
        checks++; if (owner_o !== 2'd2) begin errors++; $display("[TB] FAIL single_owner: got %0d expected %0d", owner_o, 2); end
        checks++; if (io_east_o !== 14'h0004) begin errors++; $display("[TB] FAIL single_east_o: got %h expected %h", io_east_o, 14'h0004); end
        checks++; if (io_east_oe !== 14'h3FFF) begin errors++; $display("[TB] FAIL single_east_oe: got %h expected %h", io_east_oe, 14'h3FFF); end
        checks++; if (io_west_o !== 14'h0400) begin errors++; $display("[TB] FAIL single_west_o: got %h expected %h", io_west_o, 14'h0400); end
        checks++; if (io_west_oe !== 14'h03FC) begin errors++; $display("[TB] FAIL single_west_oe: got %h expected %h", io_west_oe, 14'h03FC); end
        checks++; if (io_north_o !== 10'h080) begin errors++; $display("[TB] FAIL single_north_o: got %h expected %h", io_north_o, 10'h080); end
        checks++; if (io_north_oe !== 10'h03C) begin errors++; $display("[TB] FAIL single_north_oe: got %h expected %h", io_north_oe, 10'h03C); end
        tick();
        tick();
        req = 4'b0000;
        tick();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL release_grant: got %b expected %b", grant_o, 4'b0000); end
        checks++; if (io_east_oe !== 14'h0000) begin errors++; $display("[TB] FAIL release_east_oe: got %h expected %h", io_east_oe, 14'h0000); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL release_busy: got %b expected %b", busy_o, 1'b0); end
        checks++; if (owner_o !== 2'd2) begin errors++; $display("[TB] FAIL release_owner: got %0d expected %0d", owner_o, 2); end
        req = 4'b0100;
        tick();
        checks++; if (io_east_oe !== 14'h0000) begin errors++; $display("[TB] FAIL turn2_east_oe: got %h expected %h", io_east_oe, 14'h0000); end
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL turn2_grant: got %b expected %b", grant_o, 4'b0000); end
        tick();
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("[TB] FAIL regrant: got %b expected %b", grant_o, 4'b0100); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [13:0] exp_e;
        do_reset();
        req = 4'b1111;
        tick();
        for (int s = 0; s < 5; s++) begin
            exp_g = 4'b0001 << (s % 4);
            exp_e = 14'h0001 << (s % 4);
            checks++; if (grant_o !== exp_g) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", s, grant_o, exp_g); end
            checks++; if (owner_o !== 2'(s % 4)) begin errors++; $display("[TB] FAIL rr_owner[%0d]: got %0d expected %0d", s, owner_o, s % 4); end
            checks++; if (io_east_o !== exp_e) begin errors++; $display("[TB] FAIL rr_east_o[%0d]: got %h expected %h", s, io_east_o, exp_e); end
            if (s < 4) begin
                for (int c = 1; c < 8; c++) begin
                    tick();
                    checks++; if (grant_o !== exp_g) begin errors++; $display("[TB] FAIL rr_hold[%0d.%0d]: got %b expected %b", s, c, grant_o, exp_g); end
                end
                tick();
                checks++; if (grant_o !== 4'b0000 || io_east_oe !== 14'h0000) begin errors++; $display("[TB] FAIL rr_turn1[%0d]: got %b/%h expected 0000/0000", s, grant_o, io_east_oe); end
                tick();
                checks++; if (grant_o !== 4'b0000 || io_east_oe !== 14'h0000) begin errors++; $display("[TB] FAIL rr_turn2[%0d]: got %b/%h expected 0000/0000", s, grant_o, io_east_oe); end
                tick();
            end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_no_contender_hold();
        int bad = 0;
        do_reset();
        req = 4'b0010;
        tick();
        for (int c = 0; c < 1000; c++) begin
            tick();
            checks++;
            if (grant_o !== 4'b0010 || busy_o !== 1'b1) begin
                errors++;
                if (bad == 0) $display("[TB] FAIL hold_grant[%0d]: got %b busy %b expected 0010 busy 1", c, grant_o, busy_o);
                bad++;
            end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_release_preempt_same_cycle();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1010;
        for (int c = 1; c < 8; c++) tick();
        checks++; if (grant_o !== 4'b0010) begin errors++; $display("[TB] FAIL sim_prehold: got %b expected %b", grant_o, 4'b0010); end
        req = 4'b1000;
        tick();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL sim_turn1: got %b expected %b", grant_o, 4'b0000); end
        tick();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL sim_turn2: got %b expected %b", grant_o, 4'b0000); end
        tick();
        checks++; if (grant_o !== 4'b1000) begin errors++; $display("[TB] FAIL sim_next: got %b expected %b", grant_o, 4'b1000); end
        checks++; if (owner_o !== 2'd3) begin errors++; $display("[TB] FAIL sim_owner: got %0d expected %0d", owner_o, 3); end
        checks++; if (io_north_o !== 10'h040) begin errors++; $display("[TB] FAIL sim_north_o: got %h expected %h", io_north_o, 10'h040); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        tick();
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("[TB] FAIL mid_pre: got %b expected %b", grant_o, 4'b0100); end
        rst = 1'b1;
        #1;
        checks++; if (io_east_oe !== 14'h0000) begin errors++; $display("[TB] FAIL mid_east_oe: got %h expected %h", io_east_oe, 14'h0000); end
        checks++; if (io_west_oe !== 14'h0000) begin errors++; $display("[TB] FAIL mid_west_oe: got %h expected %h", io_west_oe, 14'h0000); end
        checks++; if (owner_o !== 2'd0) begin errors++; $display("[TB] FAIL mid_owner: got %0d expected %0d", owner_o, 0); end
        rst = 1'b0;
        tick();
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("[TB] FAIL mid_regrant: got %b expected %b", grant_o, 4'b0100); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_idle_drop();
        do_reset();
        req = 4'b0001;
        #2;
        req = 4'b0000;
        tick();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL drop_grant: got %b expected %b", grant_o, 4'b0000); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy: got %b expected %b", busy_o, 1'b0); end
    endtask

`ifdef IO_ARB_LOCK_EN
    task automatic test_lock();
        int bad = 0;
        do_reset();
        lock = 4'b0000;
        req  = 4'b0010;
        tick();
        lock = 4'b0010;
        req  = 4'b1010;
        for (int c = 0; c < 100; c++) begin
            tick();
            checks++;
            if (grant_o !== 4'b0010) begin
                errors++;
                if (bad == 0) $display("[TB] FAIL lock_hold[%0d]: got %b expected %b", c, grant_o, 4'b0010);
                bad++;
            end
        end
        lock = 4'b0000;
        tick();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL lock_preempt: got %b expected %b", grant_o, 4'b0000); end
        tick();
        tick();
        checks++; if (grant_o !== 4'b1000) begin errors++; $display("[TB] FAIL lock_next: got %b expected %b", grant_o, 4'b1000); end
        req = 4'b0000;
        tick();
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = 4'b0000;
`ifdef IO_ARB_LOCK_EN
        lock = 4'b0000;
`endif
        for (int k = 0; k < 4; k++) begin
            east_o[k*14 +: 14]   = 14'h0001 << k;
            east_oe[k*14 +: 14]  = 14'h3FFF;
            west_o[k*14 +: 14]   = 14'h1000 >> k;
            west_oe[k*14 +: 14]  = 14'h00FF << k;
            north_o[k*10 +: 10]  = 10'h200 >> k;
            north_oe[k*10 +: 10] = 10'h00F << k;
        end
        $display("[TB] starting io_pad_arbiter directed tests");
        test_reset();
        test_single_owner();
        test_round_robin();
        test_no_contender_hold();
        test_release_preempt_same_cycle();
        test_reset_mid_grant();
        test_idle_drop();
`ifdef IO_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
